bcd_even_odd_counter: RTL and testbench

Synchronous mod-10 counter that steps through the ten BCD codes in even-then-odd order: 0, 2, 4, 6, 8, 1, 3, 5, 7, 9, then back to 0. It is built as a mod-5 stage weighted ×2 plus a mod-2 stage. It has 7490-style master-reset and master-set-to-9 controls, and drives true and complemented outputs. It is a leaf counter used in sequencing and display-test logic.

---
 rtl/bcd_even_odd_counter_pkg.sv | 16 +
 rtl/bcd_even_odd_counter_mod5.sv | 37 +++
 rtl/bcd_even_odd_counter.sv | 68 ++++++
 tb/tb_bcd_even_odd_counter.sv | 109 ++++++++++
 4 files changed

// File: rtl/bcd_even_odd_counter_pkg.sv
// Shared constants and control-action encoding for the even/odd BCD counter.
package bcd_even_odd_counter_pkg;

  localparam int unsigned MOD5_W   = 3;
  localparam logic [3:0]  CNT_ZERO = 4'd0;
  localparam logic [3:0]  CNT_NINE = 4'd9;
  localparam logic [2:0]  MOD5_MAX = 3'd4;

  // One action per edge, already resolved by priority.
  typedef enum logic [1:0] {
    CTL_COUNT = 2'd0,
    CTL_CLEAR = 2'd1,
    CTL_SET9  = 2'd2
  } ctl_e;

endpackage

// File: rtl/bcd_even_odd_counter_mod5.sv
// Mod-5 stage (the x2-weighted part of the count). Priority: clear, load-4, count.
// Out-of-range values 5..7 fold back to 0 on a count edge without a wrap pulse.
module mod5_counter
  import bcd_even_odd_counter_pkg::*;
(
  input  logic              Clk,
  input  logic              clr,
  input  logic              load4,
  input  logic              cnt_en,
  output logic [MOD5_W-1:0] q5,
  output logic              wrap
);

  logic [MOD5_W-1:0] q5_d, q5_q;

  // Next-state selection for the mod-5 register.
  always_comb begin
    q5_d = q5_q;
    if (clr) begin
      q5_d = '0;
    end else if (load4) begin
      q5_d = MOD5_MAX;
    end else if (cnt_en) begin
      if (q5_q >= MOD5_MAX) q5_d = '0;
      else                  q5_d = q5_q + 3'd1;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    q5_q <= q5_d;
  end

  assign q5   = q5_q;
  assign wrap = cnt_en && (q5_q == MOD5_MAX);

endmodule

// File: rtl/bcd_even_odd_counter.sv
// Even-then-odd BCD counter: 0,2,4,6,8,1,3,5,7,9. Q = {q5, q2}.
// Optional macro MASTER_SET_EN enables the 7490-style set-to-9 (MS1&MS2);
// without it MS1/MS2 are accepted but ignored.
module bcd_even_odd_counter
  import bcd_even_odd_counter_pkg::*;
(
  input  logic       Clk,
  input  logic       rst,
  input  logic       MS1,
  input  logic       MS2,
  input  logic       MR1,
  input  logic       MR2,
  output logic [3:0] Q,
  output logic [3:0] Qbar
);

  ctl_e              ctl;
  logic              ms_act;
  logic              mr_act;
  logic [MOD5_W-1:0] q5;
  logic              wrap;
  logic              q2_d, q2_q;

`ifdef MASTER_SET_EN
  assign ms_act = MS1 & MS2;
`else
  logic unused_ms;
  assign unused_ms = MS1 ^ MS2;
  assign ms_act    = 1'b0;
`endif
  assign mr_act = MR1 & MR2;

  // Resolve controls: rst, then set (overrides MR as in the 7490), then MR, then count.
  always_comb begin
    ctl = CTL_COUNT;
    if (rst)         ctl = CTL_CLEAR;
    else if (ms_act) ctl = CTL_SET9;
    else if (mr_act) ctl = CTL_CLEAR;
  end

  mod5_counter u_mod5 (
    .Clk    (Clk),
    .clr    (ctl == CTL_CLEAR),
    .load4  (ctl == CTL_SET9),
    .cnt_en (ctl == CTL_COUNT),
    .q5     (q5),
    .wrap   (wrap)
  );

  // Mod-2 stage toggles each time the mod-5 stage wraps.
  always_comb begin
    q2_d = q2_q;
    case (ctl)
      CTL_CLEAR: q2_d = 1'b0;
      CTL_SET9:  q2_d = 1'b1;
      default:   if (wrap) q2_d = ~q2_q;
    endcase
  end

  // Mod-2 register.
  always_ff @(posedge Clk) begin
    q2_q <= q2_d;
  end

  assign Q    = {q5, q2_q};
  assign Qbar = ~Q;

endmodule

// File: tb/tb_bcd_even_odd_counter.sv
// Scoreboard bench: each driven cycle pushes its expected Q; the value is
// popped and compared one edge later.
module tb_bcd_even_odd_counter;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       MS1 = 1'b0, MS2 = 1'b0, MR1 = 1'b0, MR2 = 1'b0;
  logic [3:0] Q, Qbar;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] seq [10];
  int         idx = 0;

  always #5 Clk = ~Clk;

  bcd_even_odd_counter dut (
    .Clk  (Clk),
    .rst  (rst),
    .MS1  (MS1),
    .MS2  (MS2),
    .MR1  (MR1),
    .MR2  (MR2),
    .Q    (Q),
    .Qbar (Qbar)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input logic r, input logic s1, input logic s2,
                      input logic m1, input logic m2);
    logic [3:0] e;
    @(negedge Clk);
    rst = r; MS1 = s1; MS2 = s2; MR1 = m1; MR2 = m2;
    if (r) idx = 0;
`ifdef MASTER_SET_EN
    else if (s1 && s2) idx = 9;
`endif
    else if (m1 && m2) idx = 0;
    else idx = (idx + 1) % 10;
    exp_q.push_back(seq[idx]);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check("q", Q, e);
      check("qbar", Qbar, ~e);
      check("q_le9", {3'b0, (Q > 4'd9)}, 4'd0);
    end
  endtask

  task automatic cnt(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    seq[0] = 4'd0; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd6; seq[4] = 4'd8;
    seq[5] = 4'd1; seq[6] = 4'd3; seq[7] = 4'd5; seq[8] = 4'd7; seq[9] = 4'd9;

    step(1, 0, 0, 0, 0);          // reset -> 0 / F
    cnt(10);                       // full sequence back to 0
    cnt(3);                        // -> 6
    step(0, 0, 0, 1, 1);           // MR -> 0
    step(0, 0, 0, 1, 0);           // single MR leg -> 2
    step(0, 1, 0, 0, 0);           // single MS leg -> 4
    step(0, 1, 1, 0, 0);           // MS -> 9 (or count)
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);           // release -> wrap
    step(0, 1, 1, 1, 1);           // MS and MR together
    step(1, 1, 1, 0, 0);           // rst beats MS
    cnt(1);                        // -> 2
    step(0, 1, 1, 0, 0);           // 9 with set, else 4
    step(1, 0, 0, 0, 0);
    cnt(8);                        // -> 7
    step(1, 0, 0, 0, 0);           // mid-sequence reset
    cnt(1);                        // -> 2
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 0));
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
